// File: rtl/fft_core_pipe.sv
// Fully pipelined radix-2 DIT FFT: one registered butterfly rank per stage, with a
// single global enable that freezes the whole pipe under output backpressure.
module fft_core_pipe #(
    parameter int  FFT_LOG2    = 3,
    parameter int  DATA_INP_WD = 16,
    parameter int  DATA_W_N_WD = 16,
    parameter int  DATA_FRC_WD = 14,
    parameter int  IN_ORDER    = 0,
    localparam int N           = 1 << FFT_LOG2,
    localparam int G           = DATA_W_N_WD - DATA_FRC_WD + 1,
    localparam int DATA_OUT_WD = DATA_INP_WD + FFT_LOG2 * G
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            val_i,
    output logic                            rdy_o,
    input  logic                            inv_i,
    input  logic [N*DATA_INP_WD-1:0]        dat_fft_re_i,
    input  logic [N*DATA_INP_WD-1:0]        dat_fft_im_i,
    input  logic [(N/2)*DATA_W_N_WD-1:0]    dat_wn_re_i,
    input  logic [(N/2)*DATA_W_N_WD-1:0]    dat_wn_im_i,
    output logic                            val_o,
    input  logic                            rdy_i,
    output logic [N*DATA_OUT_WD-1:0]        dat_fft_re_o,
    output logic [N*DATA_OUT_WD-1:0]        dat_fft_im_o,
    output logic [15:0]                     cnt_frm_o
);
    localparam int PW = DATA_OUT_WD + DATA_W_N_WD + 1;
    typedef logic signed [DATA_OUT_WD-1:0] smp_t;

    function automatic int bit_rev(input int v);
        int r = 0;
        for (int b = 0; b < FFT_LOG2; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    // Handshake: a frame enters on val_i && rdy_o and leaves on val_o && rdy_i;
    // every stage advances together only when the output slot is free or being taken.
    logic                en;
    smp_t                in_re [N];
    smp_t                in_im [N];
    smp_t                re_d  [FFT_LOG2][N];
    smp_t                im_d  [FFT_LOG2][N];
    smp_t                re_q  [FFT_LOG2][N];
    smp_t                im_q  [FFT_LOG2][N];
    logic [FFT_LOG2-1:0] vld_q, vld_d;
    logic [FFT_LOG2-1:0] inv_q, inv_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                unused_inv;

    assign en    = !vld_q[FFT_LOG2-1] || rdy_i;
    assign rdy_o = en;
    assign vld_d = (vld_q << 1) | FFT_LOG2'(val_i);
    assign inv_d = (inv_q << 1) | FFT_LOG2'(inv_i);
    assign cnt_d = cnt_q + 16'd1;
    // The final stage's mode bit rides along with the frame but no butterfly follows it.
    assign unused_inv = inv_q[FFT_LOG2-1];

    for (genvar i = 0; i < N; i++) begin : g_in
        localparam int SRC = (IN_ORDER != 0) ? bit_rev(i) : i;
        assign in_re[i] = smp_t'($signed(dat_fft_re_i[(SRC+1)*DATA_INP_WD-1 -: DATA_INP_WD]));
        assign in_im[i] = smp_t'($signed(dat_fft_im_i[(SRC+1)*DATA_INP_WD-1 -: DATA_INP_WD]));
    end

    for (genvar s = 0; s < FFT_LOG2; s++) begin : g_stg
        localparam int H  = 1 << s;
        localparam int SH = DATA_OUT_WD - (DATA_INP_WD + (s + 1) * G);
        smp_t src_re [N];
        smp_t src_im [N];
        logic src_inv;

        if (s == 0) begin : g_src0
            assign src_re  = in_re;
            assign src_im  = in_im;
            assign src_inv = inv_i;
        end else begin : g_srcn
            assign src_re  = re_q[s-1];
            assign src_im  = im_q[s-1];
            assign src_inv = inv_q[s-1];
        end

        for (genvar p = 0; p < N; p++) begin : g_bfly
            if (((p >> s) & 1) == 0) begin : g_pair
                localparam int K = (p % H) << (FFT_LOG2 - 1 - s);
                logic signed [PW-1:0] br, bi, wr, wi_raw, wi, pr, pi;
                smp_t                 tr, ti, x1r, x1i, x2r, x2i;

                assign br     = PW'(src_re[p+H]);
                assign bi     = PW'(src_im[p+H]);
                assign wr     = PW'($signed(dat_wn_re_i[(K+1)*DATA_W_N_WD-1 -: DATA_W_N_WD]));
                assign wi_raw = PW'($signed(dat_wn_im_i[(K+1)*DATA_W_N_WD-1 -: DATA_W_N_WD]));
                assign wi     = src_inv ? -wi_raw : wi_raw;
                assign pr     = br * wr - bi * wi;
                assign pi     = br * wi + bi * wr;
                // Low bits of the scaled product are enough: the sum wraps at W_(s+1) anyway.
                assign tr     = smp_t'(pr >>> DATA_FRC_WD);
                assign ti     = smp_t'(pi >>> DATA_FRC_WD);
                assign x1r    = src_re[p] + tr;
                assign x1i    = src_im[p] + ti;
                assign x2r    = src_re[p] - tr;
                assign x2i    = src_im[p] - ti;
                assign re_d[s][p]   = (x1r <<< SH) >>> SH;
                assign im_d[s][p]   = (x1i <<< SH) >>> SH;
                assign re_d[s][p+H] = (x2r <<< SH) >>> SH;
                assign im_d[s][p+H] = (x2i <<< SH) >>> SH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q  <= '{default: '0};
            im_q  <= '{default: '0};
            vld_q <= '0;
            inv_q <= '0;
        end else if (en) begin
            re_q  <= re_d;
            im_q  <= im_d;
            vld_q <= vld_d;
            inv_q <= inv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (val_o && rdy_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign val_o     = vld_q[FFT_LOG2-1];
    assign cnt_frm_o = cnt_q;

    for (genvar i = 0; i < N; i++) begin : g_out
        assign dat_fft_re_o[(i+1)*DATA_OUT_WD-1 -: DATA_OUT_WD] = re_q[FFT_LOG2-1][i];
        assign dat_fft_im_o[(i+1)*DATA_OUT_WD-1 -: DATA_OUT_WD] = im_q[FFT_LOG2-1][i];
    end

endmodule

// File: tb/tb_fft_core_pipe.sv
// Bench for fft_core_pipe at N=8 (one bit-reversed-input and one natural-input instance):
// directed cases plus randomized frames, every delivered frame compared with an integer DIT model.
module tb_fft_core_pipe;
    localparam int L   = 3;
    localparam int N   = 8;
    localparam int INP = 16;
    localparam int WNW = 16;
    localparam int FRC = 14;
    localparam int G   = WNW - FRC + 1;
    localparam int OUT = INP + L * G;
    localparam int FW  = 2 * N * OUT;
    typedef logic [FW-1:0] frame_t;

    logic                  clk;
    logic                  rst_n;
    logic                  val_i, inv_i, rdy_i;
    logic [N*INP-1:0]      re_bus, im_bus;
    logic [(N/2)*WNW-1:0]  wn_re, wn_im;
    logic                  rdy_o_a, val_o_a, rdy_o_b, val_o_b;
    logic [N*OUT-1:0]      re_o_a, im_o_a, re_o_b, im_o_b;
    logic [15:0]           cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int twr [N/2] = '{16384, 11585, 0, -11585};
    int twi [N/2] = '{0, -11585, -16384, -11585};

    frame_t      exp_a_q[$];
    frame_t      exp_b_q[$];
    logic [15:0] exp_cnt_a, exp_cnt_b;

    fft_core_pipe #(.IN_ORDER(0)) u_rev (
        .clk(clk), .rst_n(rst_n), .val_i(val_i), .rdy_o(rdy_o_a), .inv_i(inv_i),
        .dat_fft_re_i(re_bus), .dat_fft_im_i(im_bus), .dat_wn_re_i(wn_re), .dat_wn_im_i(wn_im),
        .val_o(val_o_a), .rdy_i(rdy_i), .dat_fft_re_o(re_o_a), .dat_fft_im_o(im_o_a),
        .cnt_frm_o(cnt_a)
    );

    fft_core_pipe #(.IN_ORDER(1)) u_nat (
        .clk(clk), .rst_n(rst_n), .val_i(val_i), .rdy_o(rdy_o_b), .inv_i(inv_i),
        .dat_fft_re_i(re_bus), .dat_fft_im_i(im_bus), .dat_wn_re_i(wn_re), .dat_wn_im_i(wn_im),
        .val_o(val_o_b), .rdy_i(rdy_i), .dat_fft_re_o(re_o_b), .dat_fft_im_o(im_o_b),
        .cnt_frm_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < L; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v <<< (64 - w);
        return m >>> (64 - w);
    endfunction

    // Textbook iterative DIT on integers: bit-reverse the natural sequence, then
    // log2(N) ranks of butterflies, each result wrapped to the rank's output width.
    function automatic frame_t ref_fft(input logic [N*INP-1:0] bre, input logic [N*INP-1:0] bim,
                                       input bit inv, input bit nat);
        longint xr [N];
        longint xi [N];
        longint yr [N];
        longint yi [N];
        longint ar, ai, br, bi, wr, wi, tr, ti;
        int     h, k, slot;
        frame_t f;
        for (int n = 0; n < N; n++) begin
            slot  = nat ? n : bitrev(n);
            xr[n] = longint'($signed(bre[slot*INP +: INP]));
            xi[n] = longint'($signed(bim[slot*INP +: INP]));
        end
        for (int i = 0; i < N; i++) begin
            yr[i] = xr[bitrev(i)];
            yi[i] = xi[bitrev(i)];
        end
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            for (int p = 0; p < N; p++) begin
                if (((p >> s) & 1) == 0) begin
                    k  = (p % h) * (N >> (s + 1));
                    wr = twr[k];
                    wi = inv ? -twi[k] : twi[k];
                    ar = yr[p];   ai = yi[p];
                    br = yr[p+h]; bi = yi[p+h];
                    tr = (br * wr - bi * wi) >>> FRC;
                    ti = (br * wi + bi * wr) >>> FRC;
                    yr[p]   = wrap(ar + tr, INP + (s + 1) * G);
                    yi[p]   = wrap(ai + ti, INP + (s + 1) * G);
                    yr[p+h] = wrap(ar - tr, INP + (s + 1) * G);
                    yi[p+h] = wrap(ai - ti, INP + (s + 1) * G);
                end
            end
        end
        f = '0;
        for (int i = 0; i < N; i++) begin
            f[i*OUT +: OUT]     = yr[i][OUT-1:0];
            f[(N+i)*OUT +: OUT] = yi[i][OUT-1:0];
        end
        return f;
    endfunction

    function automatic logic signed [31:0] slot_val(input logic [N*OUT-1:0] bus, input int i);
        return 32'($signed(bus[i*OUT +: OUT]));
    endfunction

    task automatic chk(input string tag, input frame_t obs, input frame_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input bit inv);
        inv_i = inv;
        val_i = 1'b1;
        @(posedge clk);
        #1;
        val_i = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (val_o_a) lat = c;
        end
        if (lat == 0) chk_i("timeout_val_o", 32'(val_o_a), 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard: expected frames queued at acceptance, compared at delivery.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a_q.delete();
            exp_b_q.delete();
            exp_cnt_a = '0;
            exp_cnt_b = '0;
        end else begin
            chk_i("cnt_a", 32'(cnt_a), 32'(exp_cnt_a));
            chk_i("cnt_b", 32'(cnt_b), 32'(exp_cnt_b));
            chk_i("rdy_a", 32'(rdy_o_a), 32'(!val_o_a || rdy_i));
            if (val_i && rdy_o_a) exp_a_q.push_back(ref_fft(re_bus, im_bus, inv_i, 1'b0));
            if (val_i && rdy_o_b) exp_b_q.push_back(ref_fft(re_bus, im_bus, inv_i, 1'b1));
            if (val_o_a && rdy_i) begin
                if (exp_a_q.size() == 0) chk_i("spurious_a", 32'(val_o_a), 0);
                else chk("frame_a", {im_o_a, re_o_a}, exp_a_q.pop_front());
                exp_cnt_a = exp_cnt_a + 16'd1;
            end
            if (val_o_b && rdy_i) begin
                if (exp_b_q.size() == 0) chk_i("spurious_b", 32'(val_o_b), 0);
                else chk("frame_b", {im_o_b, re_o_b}, exp_b_q.pop_front());
                exp_cnt_b = exp_cnt_b + 16'd1;
            end
        end
    end

    initial begin
        frame_t want, held;
        int     lat;
        rst_n  = 1'b0;
        val_i  = 1'b0;
        inv_i  = 1'b0;
        rdy_i  = 1'b1;
        re_bus = '0;
        im_bus = '0;
        for (int k = 0; k < N / 2; k++) begin
            wn_re[k*WNW +: WNW] = WNW'(twr[k]);
            wn_im[k*WNW +: WNW] = WNW'(twi[k]);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_val_a", 32'(val_o_a), 0);
        chk_i("rst_val_b", 32'(val_o_b), 0);
        chk_i("rst_rdy_a", 32'(rdy_o_a), 1);
        chk_i("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_dat_a", {im_o_a, re_o_a}, '0);
        chk("rst_dat_b", {im_o_b, re_o_b}, '0);
        rst_n = 1'b1;

        // Impulse: flat spectrum after exactly three cycles
        re_bus = '0;
        re_bus[0 +: INP] = 16'd100;
        send_frame(1'b0);
        wait_out(lat);
        chk_i("imp_latency", lat, 3);
        want = '0;
        for (int i = 0; i < N; i++) want[i*OUT +: OUT] = OUT'(100);
        chk("imp_a", {im_o_a, re_o_a}, want);
        chk("imp_b", {im_o_b, re_o_b}, want);
        @(posedge clk);
        #1;

        // DC: all energy in bin 0
        re_bus = {N{16'd1000}};
        send_frame(1'b0);
        wait_out(lat);
        want = '0;
        want[0 +: OUT] = OUT'(8000);
        chk("dc_a", {im_o_a, re_o_a}, want);
        chk("dc_b", {im_o_b, re_o_b}, want);
        @(posedge clk);
        #1;

        // Single tone at x[1] on the natural-order instance, forward then inverse
        re_bus = '0;
        re_bus[INP +: INP] = 16'd1000;
        send_frame(1'b0);
        wait_out(lat);
        chk_i("fwd_x2_re", slot_val(re_o_b, 2), 0);
        chk_i("fwd_x2_im", slot_val(im_o_b, 2), -1000);
        chk_i("fwd_x4_re", slot_val(re_o_b, 4), -1000);
        chk_i("fwd_x4_im", slot_val(im_o_b, 4), 0);
        @(posedge clk);
        #1;
        send_frame(1'b1);
        wait_out(lat);
        chk_i("inv_x2_re", slot_val(re_o_b, 2), 0);
        chk_i("inv_x2_im", slot_val(im_o_b, 2), 1000);
        @(posedge clk);
        #1;

        // Randomized frames, mode and downstream readiness, including full-scale extremes
        for (int c = 0; c < 80; c++) begin
            val_i = ($urandom_range(0, 9) < 7);
            inv_i = 1'($urandom_range(0, 1));
            rdy_i = ($urandom_range(0, 3) != 0);
            if (c % 16 == 0) begin
                re_bus = {N{16'h8000}};
                im_bus = {N{16'h7fff}};
            end else begin
                re_bus = {$urandom, $urandom, $urandom, $urandom};
                im_bus = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            #1;
        end
        val_i = 1'b0;
        rdy_i = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_i("rand_drain_a", exp_a_q.size(), 0);
        chk_i("rand_drain_b", exp_b_q.size(), 0);
        @(posedge clk);
        #1;

        // Backpressure: three back-to-back frames, output stalled for five cycles
        pulse_reset();
        for (int f = 0; f < 3; f++) begin
            re_bus = {$urandom, $urandom, $urandom, $urandom};
            im_bus = {$urandom, $urandom, $urandom, $urandom};
            inv_i  = 1'($urandom_range(0, 1));
            val_i  = 1'b1;
            @(posedge clk);
            #1;
        end
        val_i = 1'b0;
        for (int c = 0; c < 10 && !val_o_a; c++) begin
            @(posedge clk);
            #1;
        end
        chk_i("bp_first_val", 32'(val_o_a), 1);
        rdy_i = 1'b0;
        held  = {im_o_a, re_o_a};
        repeat (5) begin
            @(negedge clk);
            chk_i("bp_rdy_o", 32'(rdy_o_a), 0);
            chk_i("bp_val_o", 32'(val_o_a), 1);
            chk("bp_hold", {im_o_a, re_o_a}, held);
        end
        @(posedge clk);
        #1;
        rdy_i = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_i("bp_cnt_a", 32'(cnt_a), 3);
        chk_i("bp_cnt_b", 32'(cnt_b), 3);
        chk_i("bp_drain_a", exp_a_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset with frames in flight and one at the output
        for (int f = 0; f < 3; f++) begin
            re_bus = {$urandom, $urandom, $urandom, $urandom};
            val_i  = 1'b1;
            @(posedge clk);
            #1;
        end
        val_i = 1'b0;
        chk_i("mf_pre_val", 32'(val_o_a), 1);
        rst_n = 1'b0;
        #1;
        chk_i("mf_val_a", 32'(val_o_a), 0);
        chk_i("mf_cnt_a", 32'(cnt_a), 0);
        chk("mf_dat_a", {im_o_a, re_o_a}, '0);
        chk_i("mf_rdy_a", 32'(rdy_o_a), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_i("mf_quiet_a", 32'(val_o_a), 0);
            chk_i("mf_quiet_b", 32'(val_o_b), 0);
        end
        chk_i("mf_cnt_after", 32'(cnt_a), 0);
        @(posedge clk);
        #1;

        // Frame counter wrap: 65535 deliveries, then one more
        re_bus = {$urandom, $urandom, $urandom, $urandom};
        im_bus = {$urandom, $urandom, $urandom, $urandom};
        inv_i  = 1'b0;
        val_i  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        val_i = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_i("wrap_ffff_a", 32'(cnt_a), 32'hffff);
        chk_i("wrap_ffff_b", 32'(cnt_b), 32'hffff);
        @(posedge clk);
        #1;
        send_frame(1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_i("wrap_zero_a", 32'(cnt_a), 0);
        chk_i("wrap_zero_b", 32'(cnt_b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_core_pipe.md
FFT_CORE_PIPE -- requirements
Module: fft_core_pipe

Interface
- REQ-001 SHALL have parameter FFT_LOG2, default 3, meaning points N = 2^FFT_LOG2; legal range 1..6.
- REQ-002 SHALL have parameter DATA_INP_WD, default 16, meaning signed input sample width (re and im).
- REQ-003 SHALL have parameter DATA_W_N_WD, default 16, meaning signed twiddle width.
- REQ-004 SHALL have parameter DATA_FRC_WD, default 14, meaning twiddle fractional bits.
- REQ-005 SHALL have parameter IN_ORDER, default 0, meaning 0 = input bit-reversed, 1 = input natural order, permuted internally by wiring.
- REQ-006 SHALL have derived localparams G = DATA_W_N_WD-DATA_FRC_WD+1, W_s = DATA_INP_WD+s*G, and DATA_OUT_WD = W_FFT_LOG2.
- REQ-007 SHALL have clk  input  1  clock; all state on rising edge.
- REQ-008 SHALL have rst_n  input  1  asynchronous active-low reset.
- REQ-009 SHALL have val_i  input  1  input frame valid.
- REQ-010 SHALL have rdy_o  output  1  block accepts a frame this cycle.
- REQ-011 SHALL have inv_i  input  1  inverse mode for the frame (twiddles conjugated), sampled with the frame.
- REQ-012 SHALL have dat_fft_re_i / dat_fft_im_i  input  N*DATA_INP_WD  samples; sample i at [(i+1)*DATA_INP_WD-1 -: DATA_INP_WD].
- REQ-013 SHALL have dat_wn_re_i / dat_wn_im_i  input  (N/2)*DATA_W_N_WD  twiddles W_N^k, k=0..N/2-1, same slot packing.
- REQ-014 SHALL have val_o  output  1  output frame valid.
- REQ-015 SHALL have rdy_i  input  1  downstream accepts output.
- REQ-016 SHALL have dat_fft_re_o / dat_fft_im_o  output  N*DATA_OUT_WD  results, natural order, same slot packing.
- REQ-017 SHALL have cnt_frm_o  output  16  count of frames delivered (val_o && rdy_i), wraps 0xFFFF->0.

Function
- REQ-018 SHALL implement radix-2 DIT in FFT_LOG2 stages; stage s pairs index p with p+2^s, butterfly j in group uses twiddle index j*N/2^(s+1).
- REQ-019 SHALL compute butterfly X1 = A + (B*W)>>>DATA_FRC_WD, X2 = A - (B*W)>>>DATA_FRC_WD, full-precision product, arithmetic shift (truncate to -inf), sign-extended to W_(s+1), no saturation.
- REQ-020 SHALL use W_im negated in every stage of a frame whose sampled inv_i = 1; no output scaling.
- REQ-021 SHALL register every stage output; latency from accepted input to val_o = FFT_LOG2 cycles with no stall.
- REQ-022 SHALL carry one valid bit and one inv bit per stage alongside data.
- REQ-023 SHALL use global enable en = !val_o | rdy_i; rdy_o = en; input accepted when val_i && rdy_o.
- REQ-024 SHALL, when en = 0, hold all stage registers, valid bits, and outputs unchanged.
- REQ-025 SHALL, when en = 1, advance all stages; bubbles (valid 0) propagate; throughput one frame per cycle.
- REQ-026 SHALL keep dat_fft_*_o stable while val_o && !rdy_i.
- REQ-027 SHALL increment cnt_frm_o by 1 each cycle val_o && rdy_i.
- REQ-028 SHALL require twiddle bus constant while any frame is in flight; otherwise results are unspecified.

Reset
- REQ-029 SHALL, on rst_n low, immediately clear all valid bits, inv bits, stage data, dat_fft_*_o, val_o, and cnt_frm_o to 0; rdy_o = 1 during and after reset.
- REQ-030 SHALL, on reset mid-operation, discard in-flight frames; none emerges after release.

Verification (N=8, defaults, twiddles Q2.14, W^0 = 16384)
- REQ-031 SHALL pass impulse: x[0]=100, rest 0, rdy_i=1 -> after 3 cycles val_o=1, all X[k] re=100, im=0.
- REQ-032 SHALL pass DC: all x re=1000 -> X[0] re=8000, all other outputs 0.
- REQ-033 SHALL pass inverse: IN_ORDER=1, x[1]=1000; inv_i=0 -> X[2]=(0,-1000), X[4]=(-1000,0); inv_i=1 -> X[2]=(0,+1000).
- REQ-034 SHALL pass backpressure: 3 back-to-back frames, rdy_i=0 for 5 cycles from the first val_o -> rdy_o=0, outputs held, all 3 frames delivered in order, cnt_frm_o=3.
- REQ-035 SHALL pass mid-flight reset: rst_n low 1 cycle with 2 frames in flight -> val_o=0 at once, no output for 10 cycles after release, cnt_frm_o=0.
- REQ-036 SHALL pass count wrap: cnt_frm_o preset to 0xFFFF via 65535 deliveries, one more delivery -> 0x0000.
